// File: rtl/ccu_send_pack_fsm.sv
// CTRL link packet transmitter: SYNC, id LB/HB, length LB/HB, type, then optional payload bytes.
// First byte one cycle after start; byte and enable hold while ctrl_send_ready is low.
module ccu_send_pack_fsm #(
  parameter logic [7:0] SYNC_BYTE  = 8'h5A,
  parameter int         PAYLOAD_EN = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        send_start,
  input  logic [15:0] pack_id,
  input  logic [7:0]  pack_type,
  input  logic [15:0] pack_length,
  input  logic [7:0]  payload_data,
  input  logic        payload_valid,
  output logic        payload_ready,
  output logic [7:0]  ctrl_send_data,
  output logic        ctrl_send_en,
  input  logic        ctrl_send_ready,
  output logic        busy,
  output logic        int_send_start,
  output logic        int_send_finish
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SYNC    = 4'd1,
    S_ID_LB   = 4'd2,
    S_ID_HB   = 4'd3,
    S_LEN_LB  = 4'd4,
    S_LEN_HB  = 4'd5,
    S_TYPE    = 4'd6,
    S_PAYLOAD = 4'd7,
    S_FINISH  = 4'd8
  } state_t;

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] length;
    logic [7:0]  ptype;
  } hdr_t;

  state_t      state;
  hdr_t        hdr;
  logic [15:0] pay_cnt;
  logic        beat;
  logic        pay_load;

  assign beat = ctrl_send_en && ctrl_send_ready;

  // The output register can take a new byte when empty or draining this cycle.
  assign payload_ready = (state == S_PAYLOAD) && (pay_cnt != 16'd0) &&
                         (!ctrl_send_en || ctrl_send_ready);
  assign pay_load      = payload_valid && payload_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      hdr             <= '0;
      pay_cnt         <= 16'd0;
      ctrl_send_data  <= 8'd0;
      ctrl_send_en    <= 1'b0;
      busy            <= 1'b0;
      int_send_start  <= 1'b0;
      int_send_finish <= 1'b0;
    end else begin
      int_send_start  <= 1'b0;
      int_send_finish <= 1'b0;
      case (state)
        S_IDLE: begin
          if (send_start) begin
            hdr.id         <= pack_id;
            hdr.length     <= pack_length;
            hdr.ptype      <= pack_type;
            int_send_start <= 1'b1;
            busy           <= 1'b1;
            ctrl_send_en   <= 1'b1;
            ctrl_send_data <= SYNC_BYTE;
            state          <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (beat) begin
            ctrl_send_data <= hdr.id[7:0];
            state          <= S_ID_LB;
          end
        end
        S_ID_LB: begin
          if (beat) begin
            ctrl_send_data <= hdr.id[15:8];
            state          <= S_ID_HB;
          end
        end
        S_ID_HB: begin
          if (beat) begin
            ctrl_send_data <= hdr.length[7:0];
            state          <= S_LEN_LB;
          end
        end
        S_LEN_LB: begin
          if (beat) begin
            ctrl_send_data <= hdr.length[15:8];
            state          <= S_LEN_HB;
          end
        end
        S_LEN_HB: begin
          if (beat) begin
            ctrl_send_data <= hdr.ptype;
            state          <= S_TYPE;
          end
        end
        S_TYPE: begin
          if (beat) begin
            ctrl_send_en <= 1'b0;
            if ((PAYLOAD_EN != 0) && (hdr.length != 16'd0)) begin
              pay_cnt <= hdr.length;
              state   <= S_PAYLOAD;
            end else begin
              int_send_finish <= 1'b1;
              state           <= S_FINISH;
            end
          end
        end
        S_PAYLOAD: begin
          if (pay_load) begin
            ctrl_send_data <= payload_data;
            ctrl_send_en   <= 1'b1;
            pay_cnt        <= pay_cnt - 16'd1;
          end else if (beat) begin
            ctrl_send_en <= 1'b0;
            // Counter already at zero means that beat carried the last byte.
            if (pay_cnt == 16'd0) begin
              int_send_finish <= 1'b1;
              state           <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          busy         <= 1'b0;
          ctrl_send_en <= 1'b0;
          state        <= S_IDLE;
        end
        default: begin
          state           <= S_IDLE;
          hdr             <= '0;
          pay_cnt         <= 16'd0;
          ctrl_send_data  <= 8'd0;
          ctrl_send_en    <= 1'b0;
          busy            <= 1'b0;
          int_send_start  <= 1'b0;
          int_send_finish <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccu_send_pack_fsm.sv
// Bench for ccu_send_pack_fsm: payload-enabled and header-only instances on shared stimulus,
// each checked per cycle against a byte-count model of the packet.
module tb_ccu_send_pack_fsm;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        send_start = 1'b0;
  logic [15:0] pack_id = 16'd0;
  logic [7:0]  pack_type = 8'd0;
  logic [15:0] pack_length = 16'd0;
  logic [7:0]  payload_data;
  logic        payload_valid = 1'b0;
  logic        ctrl_send_ready = 1'b0;

  logic        pr0, pr1, en0, en1, busy0, busy1, st0, st1, fin0, fin1;
  logic [7:0]  dat0, dat1;

  logic [7:0]  src [256];
  int          src_idx = 0;
  assign payload_data = src[src_idx[7:0]];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int vld_mode = 0;
  int pat_i = 0;

  // Model state per instance: 0 = payload enabled, 1 = header only.
  int         m_act [2];
  int         m_fin [2];
  int         m_busy[2];
  int         m_st  [2];
  int         m_hb  [2];
  int         m_cons[2];
  int         m_pb  [2];
  int         m_len [2];
  int         m_base[2];
  logic [7:0] m_hdr [2][6];
  int         st_cnt [2];
  int         fin_cnt[2];
  int         fin_cyc[2];
  logic [7:0] lg0[$];
  logic [7:0] lg1[$];
  int         lgc0[$];
  int         lgc1[$];

  ccu_send_pack_fsm #(.SYNC_BYTE(8'h5A), .PAYLOAD_EN(1)) u_dut (
    .clk(clk), .resetn(resetn), .send_start(send_start), .pack_id(pack_id),
    .pack_type(pack_type), .pack_length(pack_length), .payload_data(payload_data),
    .payload_valid(payload_valid), .payload_ready(pr0), .ctrl_send_data(dat0),
    .ctrl_send_en(en0), .ctrl_send_ready(ctrl_send_ready), .busy(busy0),
    .int_send_start(st0), .int_send_finish(fin0)
  );

  ccu_send_pack_fsm #(.SYNC_BYTE(8'h5A), .PAYLOAD_EN(0)) u_dut_hdr (
    .clk(clk), .resetn(resetn), .send_start(send_start), .pack_id(pack_id),
    .pack_type(pack_type), .pack_length(pack_length), .payload_data(payload_data),
    .payload_valid(payload_valid), .payload_ready(pr1), .ctrl_send_data(dat1),
    .ctrl_send_en(en1), .ctrl_send_ready(ctrl_send_ready), .busy(busy1),
    .int_send_start(st1), .int_send_finish(fin1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Upstream source advances only on an observed handshake of the payload instance.
  always @(posedge clk) begin
    if (resetn && payload_valid && pr0) src_idx <= src_idx + 1;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: ctrl_send_ready = 1'b1;
        1: ctrl_send_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
        2: ctrl_send_ready = 1'($urandom_range(0, 1));
        default: ctrl_send_ready = 1'b0;
      endcase
      case (vld_mode)
        0: payload_valid = 1'b0;
        1: payload_valid = 1'b1;
        default: payload_valid = 1'($urandom_range(0, 1));
      endcase
      pat_i++;
    end
  end

  always @(negedge clk) begin
    logic       en_a, busy_a, st_a, fin_a, pr_a;
    logic [7:0] dat_a, dat_e;
    logic       en_e, pr_e, beat, load;
    int         ix;
    for (int k = 0; k < 2; k++) begin
      en_a   = (k == 0) ? en0   : en1;
      busy_a = (k == 0) ? busy0 : busy1;
      st_a   = (k == 0) ? st0   : st1;
      fin_a  = (k == 0) ? fin0  : fin1;
      pr_a   = (k == 0) ? pr0   : pr1;
      dat_a  = (k == 0) ? dat0  : dat1;
      if (!resetn) begin
        chk($sformatf("rst_en%0d@%0d", k, cyc), en_a, 0);
        chk($sformatf("rst_busy%0d@%0d", k, cyc), busy_a, 0);
        chk($sformatf("rst_start%0d@%0d", k, cyc), st_a, 0);
        chk($sformatf("rst_finish%0d@%0d", k, cyc), fin_a, 0);
        chk($sformatf("rst_pready%0d@%0d", k, cyc), pr_a, 0);
        m_act[k] = 0; m_fin[k] = 0; m_busy[k] = 0; m_st[k] = 0;
        m_hb[k] = 0; m_cons[k] = 0; m_pb[k] = 0; m_len[k] = 0;
      end else begin
        en_e = (m_act[k] != 0) && ((m_hb[k] < 6) || (m_cons[k] > m_pb[k]));
        ix = (m_base[k] + m_pb[k]) & 255;
        dat_e = (m_hb[k] < 6) ? m_hdr[k][m_hb[k] % 6] : src[ix];
        pr_e = (m_act[k] != 0) && (m_hb[k] == 6) && (m_cons[k] < m_len[k]) &&
               (!en_e || ctrl_send_ready);
        chk($sformatf("en%0d@%0d", k, cyc), en_a, en_e);
        chk($sformatf("busy%0d@%0d", k, cyc), busy_a, m_busy[k] != 0);
        chk($sformatf("start%0d@%0d", k, cyc), st_a, m_st[k] != 0);
        chk($sformatf("finish%0d@%0d", k, cyc), fin_a, m_fin[k] != 0);
        chk($sformatf("pready%0d@%0d", k, cyc), pr_a, pr_e);
        if (en_e) chk($sformatf("data%0d@%0d", k, cyc), dat_a, dat_e);
        if (en_a && ctrl_send_ready) begin
          if (k == 0) begin lg0.push_back(dat_a); lgc0.push_back(cyc); end
          else        begin lg1.push_back(dat_a); lgc1.push_back(cyc); end
        end
        if (st_a) st_cnt[k]++;
        if (fin_a) begin fin_cnt[k]++; fin_cyc[k] = cyc; end

        beat = en_e && ctrl_send_ready;
        load = payload_valid && pr_e;
        m_st[k] = 0;
        if (m_fin[k] != 0) begin
          m_fin[k] = 0;
          m_busy[k] = 0;
        end else if (m_act[k] != 0) begin
          if (beat) begin
            if (m_hb[k] < 6) m_hb[k]++;
            else m_pb[k]++;
          end
          if (load) m_cons[k]++;
          if (beat && (m_hb[k] == 6) && (m_pb[k] == m_len[k])) begin
            m_act[k] = 0;
            m_fin[k] = 1;
          end
        end else if (send_start) begin
          m_act[k] = 1; m_busy[k] = 1; m_st[k] = 1;
          m_hb[k] = 0; m_cons[k] = 0; m_pb[k] = 0;
          m_len[k] = (k == 0) ? int'(pack_length) : 0;
          m_base[k] = src_idx;
          m_hdr[k][0] = 8'h5A;         m_hdr[k][1] = pack_id[7:0];
          m_hdr[k][2] = pack_id[15:8]; m_hdr[k][3] = pack_length[7:0];
          m_hdr[k][4] = pack_length[15:8]; m_hdr[k][5] = pack_type;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt(input logic [15:0] id, input logic [15:0] len, input logic [7:0] typ);
    pack_id = id; pack_length = len; pack_type = typ;
    send_start = 1'b1;
    tick();
    send_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (((m_busy[0] != 0) || (m_busy[1] != 0)) && (n < 3000)) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < 3000, 1);
    tick();
  endtask

  task automatic clear_logs();
    lg0.delete(); lg1.delete(); lgc0.delete(); lgc1.delete();
    st_cnt[0] = 0; st_cnt[1] = 0; fin_cnt[0] = 0; fin_cnt[1] = 0;
  endtask

  initial begin
    logic [7:0] e1[6];
    logic [7:0] e3[9];
    logic [7:0] e5[6];
    logic [7:0] e6[6];
    int idx0;
    for (int i = 0; i < 256; i++) src[i] = 8'($urandom);
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_fin[k] = 0; m_busy[k] = 0; m_st[k] = 0; m_hb[k] = 0;
      m_cons[k] = 0; m_pb[k] = 0; m_len[k] = 0; m_base[k] = 0;
      st_cnt[k] = 0; fin_cnt[k] = 0; fin_cyc[k] = -1;
    end
    #1 resetn = 1'b0;
    repeat (3) tick();
    chk("reset_en", en0, 0);
    chk("reset_data", dat0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_pready", pr0, 0);
    resetn = 1'b1;
    tick();

    // Header only at full rate.
    rdy_mode = 0; vld_mode = 0;
    clear_logs();
    start_pkt(16'h1234, 16'h0000, 8'h07);
    wait_idle();
    e1 = '{8'h5A, 8'h34, 8'h12, 8'h00, 8'h00, 8'h07};
    chk("t1_nbeats", lg0.size(), 6);
    if (lg0.size() == 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("t1_byte%0d", i), lg0[i], e1[i]);
      for (int i = 1; i < 6; i++) chk($sformatf("t1_cyc%0d", i), lgc0[i] - lgc0[0], i);
      chk("t1_finish_cyc", fin_cyc[0] - lgc0[5], 1);
    end
    chk("t1_nstart", st_cnt[0], 1);
    chk("t1_nfinish", fin_cnt[0], 1);

    // Backpressure pattern 1,0,0,1.
    clear_logs();
    rdy_mode = 1; pat_i = 0;
    start_pkt(16'hA55A, 16'h0000, 8'h42);
    wait_idle();
    chk("t2_nbeats", lg0.size(), 6);
    if (lg0.size() == 6) begin
      chk("t2_id_lb", lg0[1], 8'h5A);
      chk("t2_id_hb", lg0[2], 8'hA5);
      chk("t2_type", lg0[5], 8'h42);
    end

    // Payload of three with a fourth byte left waiting.
    clear_logs();
    rdy_mode = 0; vld_mode = 1;
    idx0 = src_idx;
    src[(idx0 + 0) & 255] = 8'hA1; src[(idx0 + 1) & 255] = 8'hB2;
    src[(idx0 + 2) & 255] = 8'hC3; src[(idx0 + 3) & 255] = 8'hD4;
    start_pkt(16'h0102, 16'h0003, 8'h3C);
    wait_idle();
    repeat (3) tick();
    e3 = '{8'h5A, 8'h02, 8'h01, 8'h03, 8'h00, 8'h3C, 8'hA1, 8'hB2, 8'hC3};
    chk("t3_nbeats", lg0.size(), 9);
    if (lg0.size() == 9) begin
      for (int i = 0; i < 9; i++) chk($sformatf("t3_byte%0d", i), lg0[i], e3[i]);
      chk("t3_pay_b2b", lgc0[8] - lgc0[6], 2);
    end
    chk("t3_consumed", src_idx - idx0, 3);
    chk("t3_hdr_only_nbeats", lg1.size(), 6);

    // Restart while busy must be ignored.
    clear_logs();
    vld_mode = 2; rdy_mode = 2;
    start_pkt(16'h4455, 16'h0002, 8'h11);
    start_pkt(16'hBEEF, 16'h0007, 8'hFF);
    wait_idle();
    chk("t4_nbeats", lg0.size(), 8);
    if (lg0.size() >= 4) begin
      chk("t4_id_lb", lg0[1], 8'h55);
      chk("t4_id_hb", lg0[2], 8'h44);
      chk("t4_len_lb", lg0[3], 8'h02);
    end
    chk("t4_nstart", st_cnt[0], 1);
    chk("t4_nfinish", fin_cnt[0], 1);

    // Asynchronous reset in the ID_HB state.
    clear_logs();
    rdy_mode = 0; vld_mode = 0;
    start_pkt(16'h3344, 16'h0000, 8'h55);
    tick();
    tick();
    chk("t5_beats_before_rst", lg0.size(), 2);
    resetn = 1'b0;
    #1;
    chk("t5_async_en", en0, 0);
    chk("t5_async_busy", busy0, 0);
    chk("t5_async_data", dat0, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("t5_no_finish", fin_cnt[0], 0);
    clear_logs();
    start_pkt(16'h7788, 16'h0000, 8'h22);
    wait_idle();
    e5 = '{8'h5A, 8'h88, 8'h77, 8'h00, 8'h00, 8'h22};
    chk("t5_nbeats", lg0.size(), 6);
    if (lg0.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("t5_byte%0d", i), lg0[i], e5[i]);
    chk("t5_nfinish", fin_cnt[0], 1);

    // Header-only instance ignores the length.
    clear_logs();
    rdy_mode = 2; vld_mode = 2;
    start_pkt(16'h9999, 16'h0005, 8'h66);
    wait_idle();
    e6 = '{8'h5A, 8'h99, 8'h99, 8'h05, 8'h00, 8'h66};
    chk("t6_nbeats", lg1.size(), 6);
    if (lg1.size() == 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("t6_byte%0d", i), lg1[i], e6[i]);
      chk("t6_finish_cyc", fin_cyc[1] - lgc1[5], 1);
    end
    chk("t6_payload_nbeats", lg0.size(), 11);

    // Random packets with random flow control and stray restarts.
    for (int n = 0; n < 30; n++) begin
      rdy_mode = $urandom_range(0, 2);
      vld_mode = $urandom_range(1, 2);
      start_pkt(16'($urandom), 16'($urandom_range(0, 6)), 8'($urandom));
      for (int j = 0; j < 4; j++) begin
        pack_id = 16'($urandom); pack_length = 16'($urandom_range(0, 6));
        pack_type = 8'($urandom);
        send_start = 1'($urandom_range(0, 1));
        tick();
      end
      send_start = 1'b0;
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
